// File: rtl/hps_reset_req_gen.sv
// hps_reset_req_gen: FPGA-side source of the HPS cold/warm/debug reset requests.
// The debounced pushbutton gives a warm request on a short press and a cold
// request on a long press. Edge-triggered In-System Sources & Probes requests
// are accepted when HPS_RESET_REQ_ISSP_EN is defined. Each request is a
// fixed-width active-low pulse. After the pulse the block locks out new
// requests until the HPS has gone through reset, or until a timeout expires.
module hps_reset_req_gen #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 150000000,
  parameter int PULSE_CYCLES      = 64,
  parameter int WAIT_CYCLES       = 50000000,
  parameter int CNT_W             = 28
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       user_pb_n,
  input  logic [2:0] issp_req,
  input  logic       h2f_reset_n,
  output logic       cold_req_n,
  output logic       warm_req_n,
  output logic       debug_req_n,
  output logic       busy,
  output logic [1:0] last_req
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_WARM  = 2'b01;
  localparam logic [1:0] REQ_COLD  = 2'b10;
  localparam logic [1:0] REQ_DEBUG = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);

  logic             pb_meta_r, pb_sync_r, pb_stable_r, pb_prev_r;
  logic [CNT_W-1:0] deb_cnt_r;
  logic             hps_meta_r, hps_up_r;
  logic             press_s, rel_s;
  logic [2:0]       issp_rise_s;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] timer_r, timer_s;
  logic             seen_low_r, seen_low_s;
  logic [1:0]       last_req_r, last_req_s;
  logic             cold_req_n_r, warm_req_n_r, busy_r;

  // Two-stage synchronizers for the pushbutton and the HPS reset indication.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pb_meta_r  <= 1'b1;
      pb_sync_r  <= 1'b1;
      hps_meta_r <= 1'b0;
      hps_up_r   <= 1'b0;
    end else begin
      pb_meta_r  <= user_pb_n;
      pb_sync_r  <= pb_meta_r;
      hps_meta_r <= h2f_reset_n;
      hps_up_r   <= hps_meta_r;
    end
  end

  // Debounce: accept a new level only once it has held for DEBOUNCE_CYCLES.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      deb_cnt_r   <= CNT_ZERO;
      pb_stable_r <= 1'b1;
      pb_prev_r   <= 1'b1;
    end else begin
      pb_prev_r <= pb_stable_r;
      if (pb_sync_r == pb_stable_r) begin
        deb_cnt_r <= CNT_ZERO;
      end else if (deb_cnt_r == DEB_LAST) begin
        deb_cnt_r   <= CNT_ZERO;
        pb_stable_r <= pb_sync_r;
      end else begin
        deb_cnt_r <= deb_cnt_r + CNT_ONE;
      end
    end
  end

  assign press_s = pb_prev_r & ~pb_stable_r;
  assign rel_s   = ~pb_prev_r & pb_stable_r;

`ifdef HPS_RESET_REQ_ISSP_EN
  logic [2:0] issp_meta_r, issp_sync_r, issp_prev_r;
  logic       debug_req_n_r;

  // Synchronize the ISSP levels and keep the previous level for edge detection.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      issp_meta_r <= 3'b000;
      issp_sync_r <= 3'b000;
      issp_prev_r <= 3'b000;
    end else begin
      issp_meta_r <= issp_req;
      issp_sync_r <= issp_meta_r;
      issp_prev_r <= issp_sync_r;
    end
  end

  assign issp_rise_s = issp_sync_r & ~issp_prev_r;

  // Registered debug request: low only while pulsing a debug request.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      debug_req_n_r <= 1'b1;
    end else begin
      debug_req_n_r <= !((state_s == ST_PULSE) && (last_req_s == REQ_DEBUG));
    end
  end

  assign debug_req_n = debug_req_n_r;
`else
  // The ISSP input stays on the port but has no effect in this build.
  logic unused_issp_s;
  assign unused_issp_s = ^issp_req;
  assign issp_rise_s   = 3'b000;
  assign debug_req_n   = 1'b1;
`endif

  // Next-state logic: request selection, press timing, pulse and lockout.
  always_comb begin
    state_s    = state_r;
    last_req_s = last_req_r;
    seen_low_s = seen_low_r;
    case (state_r)
      ST_IDLE: begin
        seen_low_s = 1'b0;
        if (hps_up_r && (issp_rise_s != 3'b000)) begin
          state_s = ST_PULSE;
          if (issp_rise_s[0]) begin
            last_req_s = REQ_COLD;
          end else if (issp_rise_s[1]) begin
            last_req_s = REQ_WARM;
          end else begin
            last_req_s = REQ_DEBUG;
          end
        end else if (hps_up_r && press_s) begin
          state_s = ST_PRESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!hps_up_r) begin
          state_s = ST_IDLE;
        end else if (rel_s) begin
          state_s    = ST_PULSE;
          last_req_s = REQ_WARM;
        end else if (timer_r == LONG_LAST) begin
          state_s    = ST_PULSE;
          last_req_s = REQ_COLD;
        end else begin
          state_s = ST_PRESS;
        end
      end
      ST_PULSE: begin
        if (timer_r == PULSE_LAST) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_PULSE;
        end
      end
      ST_WAIT: begin
        if (!hps_up_r) begin
          seen_low_s = 1'b1;
        end else begin
          seen_low_s = seen_low_r;
        end
        // Never leave while the button is still held, or a stale press would re-fire.
        if (pb_stable_r && ((seen_low_r && hps_up_r) || (timer_r >= WAIT_LAST))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        last_req_s = REQ_NONE;
        seen_low_s = 1'b0;
      end
    endcase
    // One shared timer: restarts on every state change, saturates otherwise.
    if (state_s != state_r) begin
      timer_s = CNT_ZERO;
    end else if (timer_r != CNT_MAX) begin
      timer_s = timer_r + CNT_ONE;
    end else begin
      timer_s = timer_r;
    end
  end

  // State, timer and registered outputs, all derived from the next state.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_r      <= ST_IDLE;
      timer_r      <= CNT_ZERO;
      seen_low_r   <= 1'b0;
      last_req_r   <= REQ_NONE;
      cold_req_n_r <= 1'b1;
      warm_req_n_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      seen_low_r   <= seen_low_s;
      last_req_r   <= last_req_s;
      cold_req_n_r <= !((state_s == ST_PULSE) && (last_req_s == REQ_COLD));
      warm_req_n_r <= !((state_s == ST_PULSE) && (last_req_s == REQ_WARM));
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign cold_req_n = cold_req_n_r;
  assign warm_req_n = warm_req_n_r;
  assign busy       = busy_r;
  assign last_req   = last_req_r;

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// Directed bench for hps_reset_req_gen with a small request scoreboard.
// ISSP scenarios run when HPS_RESET_REQ_ISSP_EN is defined; otherwise the
// bench checks that the ISSP input is ignored.
module tb_hps_reset_req_gen;

  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int PUL   = 3;
  localparam int WAITC = 50;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n;
  logic       user_pb_n;
  logic [2:0] issp_req;
  logic       h2f_reset_n;
  logic       cold_req_n, warm_req_n, debug_req_n, busy;
  logic [1:0] last_req;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    string      tag;
    logic [2:0] low;   // {debug, warm, cold} expected low
    logic [1:0] last;
  } exp_t;
  exp_t sb_q[$];

  hps_reset_req_gen #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .PULSE_CYCLES     (PUL),
    .WAIT_CYCLES      (WAITC),
    .CNT_W            (28)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset_n(sys_reset_n),
    .user_pb_n  (user_pb_n),
    .issp_req   (issp_req),
    .h2f_reset_n(h2f_reset_n),
    .cold_req_n (cold_req_n),
    .warm_req_n (warm_req_n),
    .debug_req_n(debug_req_n),
    .busy       (busy),
    .last_req   (last_req)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_exp(input string tag, input logic [2:0] low, input logic [1:0] last);
    exp_t e;
    e.tag  = tag;
    e.low  = low;
    e.last = last;
    sb_q.push_back(e);
  endtask

  // Watch n cycles in which nothing may happen: no request, busy low.
  task automatic idle_watch(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || {debug_req_n, warm_req_n, cold_req_n} !== 3'b111) bad = 1'b1;
    end
    check(tag, bad, 0);
  endtask

  // Wait (bounded) for a request pulse, then pop and compare the scoreboard.
  task automatic wait_pulse(input int exp_lat);
    exp_t       e;
    logic [2:0] low;
    int         lat;
    int         w;
    lat = 0;
    while ({debug_req_n, warm_req_n, cold_req_n} === 3'b111 && lat < 200) begin
      @(negedge sys_clk);
      lat++;
    end
    low = ~{debug_req_n, warm_req_n, cold_req_n};
    check("sb_pending", (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
    end else begin
      e.tag  = "none";
      e.low  = 3'b000;
      e.last = 2'b00;
    end
    check({e.tag, "_latency"}, lat, exp_lat);
    check({e.tag, "_which"}, low, e.low);
    check({e.tag, "_last_req"}, last_req, e.last);
    check({e.tag, "_busy"}, busy, 1);
    w = 1;
    while (w < 100) begin
      @(negedge sys_clk);
      if ({debug_req_n, warm_req_n, cold_req_n} === 3'b111) break;
      w++;
    end
    check({e.tag, "_width"}, w, PUL);
  endtask

  initial begin
    int   k;
    int   t0;
    logic bad;

    sys_reset_n = 1'b0;
    user_pb_n   = 1'b1;
    issp_req    = 3'b000;
    h2f_reset_n = 1'b1;
    cycles(3);
    check("rst_cold", cold_req_n, 1);
    check("rst_warm", warm_req_n, 1);
    check("rst_debug", debug_req_n, 1);
    check("rst_busy", busy, 0);
    check("rst_last", last_req, 0);
    sys_reset_n = 1'b1;
    cycles(5);

    // Bounce: 3-cycle glitches never survive the debouncer.
    for (int g = 0; g < 3; g++) begin
      user_pb_n = 1'b0;
      idle_watch(3, "bounce_low");
      user_pb_n = 1'b1;
      idle_watch(10, "bounce_high");
    end
    check("bounce_last", last_req, 0);

    // Short press: warm request, then HPS handshake ends the lockout.
    push_exp("short_warm", 3'b010, 2'b01);
    user_pb_n = 1'b0;
    cycles(10);
    user_pb_n = 1'b1;
    wait_pulse(DEB + 3);
    check("short_wait_busy", busy, 1);
    h2f_reset_n = 1'b0;
    cycles(5);
    h2f_reset_n = 1'b1;
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    check("short_busy_fall", (k >= 2 && k <= 3), 1);
    check("short_last_after", last_req, 1);

    // Long press: cold request without release; lockout holds until release.
    push_exp("long_cold", 3'b001, 2'b10);
    t0 = cyc;
    user_pb_n = 1'b0;
    wait_pulse(DEB + 3 + LONG);
    check("long_wait_busy", busy, 1);
    h2f_reset_n = 1'b0;
    cycles(5);
    h2f_reset_n = 1'b1;
    cycles(4);
    check("long_busy_held", busy, 1);
    while (cyc - t0 < 40) @(negedge sys_clk);
    user_pb_n = 1'b1;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(negedge sys_clk);
      k++;
    end
    check("long_busy_fall", k, DEB + 3);
    check("long_last_after", last_req, 2);
    cycles(3);

`ifdef HPS_RESET_REQ_ISSP_EN
    // ISSP cold+warm together: cold wins; repeats in WAIT ignored; timeout exit.
    push_exp("issp_cold", 3'b001, 2'b10);
    t0 = cyc;
    issp_req = 3'b011;
    wait_pulse(3);
    issp_req = 3'b000;
    cycles(3);
    issp_req = 3'b110;
    bad = 1'b0;
    k   = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge sys_clk);
      k++;
      if ({debug_req_n, warm_req_n, cold_req_n} !== 3'b111) bad = 1'b1;
    end
    check("issp_wait_ignored", bad, 0);
    check("issp_timeout", cyc - t0, 3 + PUL + WAITC);
    issp_req = 3'b000;
    cycles(3);

    // Debug request alone.
    push_exp("issp_debug", 3'b100, 2'b11);
    issp_req = 3'b100;
    wait_pulse(3);
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    check("issp_debug_idle", busy, 0);
    issp_req = 3'b000;
    cycles(3);
`endif

    // Asynchronous reset in the second pulse cycle clears everything at once.
    user_pb_n = 1'b0;
    cycles(10);
    user_pb_n = 1'b1;
    k = 0;
    while (warm_req_n === 1'b1 && k < 40) begin
      @(negedge sys_clk);
      k++;
    end
    check("rstmid_lat", k, DEB + 3);
    @(negedge sys_clk);
    check("rstmid_low", warm_req_n, 0);
    sys_reset_n = 1'b0;
    #1;
    check("rstmid_warm", warm_req_n, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_last", last_req, 0);
    cycles(2);
    sys_reset_n = 1'b1;
    idle_watch(20, "rstmid_idle");

`ifndef HPS_RESET_REQ_ISSP_EN
    // ISSP disabled: requests on the port have no effect.
    issp_req = 3'b100;
    idle_watch(20, "issp_dis_debug");
    issp_req = 3'b011;
    idle_watch(20, "issp_dis_cold");
    check("issp_dis_last", last_req, 0);
    issp_req = 3'b000;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
